// File: rtl/coproc_pkg.sv
// Shared opcode values and dispatcher state encoding for the matrix coprocessor front end.
package coproc_pkg;

    localparam logic [3:0] OP_READ  = 4'b0001;
    localparam logic [3:0] OP_WRITE = 4'b0010;
    localparam logic [3:0] OP_SUM   = 4'b0011;
    localparam logic [3:0] OP_DET5  = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Legal opcodes are contiguous: READ, WRITE, then the matrix ops SUM..DET5.
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op == OP_READ) || (op == OP_WRITE) || ((op >= OP_SUM) && (op <= OP_DET5));
    endfunction

endpackage

// File: rtl/coproc_dispatcher_fifo.sv
// Synchronous 32-bit instruction FIFO; head word is visible on rdata_o whenever not empty.
module instr_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push against a full FIFO is dropped even if a pop frees a slot that cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/coproc_dispatcher.sv
// Host-side dispatcher: queues instructions, issues them one at a time to the coprocessor,
// captures READ results and reports overflow/timeout errors.
//
//   state    | meaning
//   IDLE     | waiting for a FIFO entry; pops head (or discards illegal opcode)
//   ISSUE    | cp_activate pulse, timeout counter cleared
//   WAIT     | waiting for cp_done, timeout counter running
//   DONE     | capture read data for READ, then back to IDLE
module coproc_dispatcher
    import coproc_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 4,
    parameter int TIMEOUT    = 4096,
    parameter int TMO_W      = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      host_instr,
    input  logic             host_wr,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic [CNT_W-1:0] fifo_count,
    output logic             busy,
    output logic [15:0]      rd_data,
    output logic             rd_valid,
    input  logic             rd_ack,
    output logic             err_overflow,
    output logic             err_timeout,
    input  logic             err_clr,
    output logic [31:0]      cp_instr,
    output logic             cp_activate,
    input  logic             cp_done,
    input  logic [15:0]      cp_data_read
);

    state_e      state_q, state_d;
    logic [31:0] cp_instr_q, cp_instr_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        err_ovf_q, err_ovf_d;
    logic        err_tmo_q, err_tmo_d;
    logic        tmo_hit;
    logic        fifo_pop;
    logic [31:0] fifo_head;
    logic [3:0]  head_op;

    instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (host_wr),
        .pop_i   (fifo_pop),
        .wdata_i (host_instr),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head_op = fifo_head[3:0];

    always_comb begin
        state_d    = state_q;
        cp_instr_d = cp_instr_q;
        tmo_d      = tmo_q;
        fifo_pop   = 1'b0;
        tmo_hit    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (!op_is_legal(head_op)) begin
                        fifo_pop = 1'b1;
                    end else if (!((head_op == OP_READ) && rd_valid_q)) begin
                        // A READ must not overwrite an unconsumed result, so it waits here.
                        fifo_pop   = 1'b1;
                        cp_instr_d = fifo_head;
                        state_d    = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cp_done) begin
                    state_d = ST_DONE;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    tmo_hit = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Set terms are applied after clear terms so a simultaneous event wins.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        err_ovf_d  = err_ovf_q;
        err_tmo_d  = err_tmo_q;
        if (rd_ack) rd_valid_d = 1'b0;
        if ((state_q == ST_DONE) && (cp_instr_q[3:0] == OP_READ)) begin
            rd_data_d  = cp_data_read;
            rd_valid_d = 1'b1;
        end
        if (err_clr) begin
            err_ovf_d = 1'b0;
            err_tmo_d = 1'b0;
        end
        if (host_wr && fifo_full) err_ovf_d = 1'b1;
        if (tmo_hit)              err_tmo_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cp_instr_q <= '0;
            tmo_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_tmo_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cp_instr_q <= cp_instr_d;
            tmo_q      <= tmo_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_ovf_q  <= err_ovf_d;
            err_tmo_q  <= err_tmo_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign cp_activate  = (state_q == ST_ISSUE);
    assign cp_instr     = cp_instr_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign err_overflow = err_ovf_q;
    assign err_timeout  = err_tmo_q;

endmodule

// File: tb/tb_coproc_dispatcher.sv
// Self-checking bench for coproc_dispatcher: a coprocessor model with an issue scoreboard,
// a table of single-instruction transactions, and hand-written multi-cycle sequences.
module tb_coproc_dispatcher;

    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = 4;
    localparam int TIMEOUT    = 4096;
    localparam int TMO_W      = 13;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [31:0]      host_instr = '0;
    logic             host_wr = 1'b0;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             busy;
    logic [15:0]      rd_data;
    logic             rd_valid;
    logic             rd_ack = 1'b0;
    logic             err_overflow;
    logic             err_timeout;
    logic             err_clr = 1'b0;
    logic [31:0]      cp_instr;
    logic             cp_activate;
    logic             cp_done = 1'b0;
    logic [15:0]      cp_data_read = '0;

    always #5 clk = ~clk;

    coproc_dispatcher #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .TMO_W      (TMO_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .host_instr   (host_instr),
        .host_wr      (host_wr),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_count   (fifo_count),
        .busy         (busy),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_ack       (rd_ack),
        .err_overflow (err_overflow),
        .err_timeout  (err_timeout),
        .err_clr      (err_clr),
        .cp_instr     (cp_instr),
        .cp_activate  (cp_activate),
        .cp_done      (cp_done),
        .cp_data_read (cp_data_read)
    );

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] exp_q[$];
    int          n_act = 0;
    int          resp_delay = 1;
    logic [15:0] resp_data = '0;
    bit          ack_at_done = 1'b0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] instr;
        int          delay;
        logic [15:0] data;
        int          exp_act;
        int          exp_busy;
        logic        exp_rdv;
        logic [15:0] exp_rdd;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [31:0] w, input bit expect_issue);
        host_instr = w;
        host_wr    = 1'b1;
        if (expect_issue) exp_q.push_back(w);
        @(negedge clk);
        host_wr = 1'b0;
    endtask

    task automatic wait_quiet(input int budget, input string name);
        int k = 0;
        while (!(fifo_empty && !busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) begin
            n_total++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", name, budget);
        end
    endtask

    // Coprocessor model: checks every issued word against the scoreboard and answers
    // with cp_done resp_delay cycles after the activate pulse (0 = never answer).
    task automatic coproc_model();
        forever begin
            @(negedge clk);
            if (cp_activate === 1'b1) begin
                int d;
                n_act++;
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_unexpected_issue: got cp_instr 0x%0h, expected no issue", cp_instr);
                end else begin
                    check("sb_cp_instr", cp_instr, exp_q.pop_front());
                end
                d = resp_delay;
                if (d > 0) begin
                    repeat (d) @(negedge clk);
                    cp_done      = 1'b1;
                    cp_data_read = resp_data;
                    @(negedge clk);
                    cp_done = 1'b0;
                    if (ack_at_done) begin
                        rd_ack = 1'b1;
                        @(negedge clk);
                        rd_ack = 1'b0;
                    end
                end
            end
        end
    endtask

    initial begin
        int act0;
        int busy_n;
        int k;
        int t_cyc;
        int last;

        vecs[0] = '{32'h0000_0012, 5, 16'h0000, 1, 7, 1'b0, 16'h0000};
        vecs[1] = '{32'h0000_0341, 3, 16'h00AB, 1, 5, 1'b1, 16'h00AB};
        vecs[2] = '{32'h0000_0003, 1, 16'h0000, 1, 3, 1'b0, 16'h0000};
        vecs[3] = '{32'h0000_000F, 1, 16'h0000, 0, 0, 1'b0, 16'h0000};
        vecs[4] = '{32'h0000_0000, 1, 16'h0000, 0, 0, 1'b0, 16'h0000};
        vecs[5] = '{32'hDEAD_000C, 2, 16'h7777, 1, 4, 1'b0, 16'h0000};
        vecs[6] = '{32'h1234_0001, 7, 16'h5A5A, 1, 9, 1'b1, 16'h5A5A};
        vecs[7] = '{32'h0000_000D, 1, 16'h0000, 0, 0, 1'b0, 16'h0000};

        fork
            coproc_model();
        join_none

        // Reset values
        step(3);
        check("rst_fifo_empty", 32'(fifo_empty), 32'd1);
        check("rst_fifo_full", 32'(fifo_full), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_err_overflow", 32'(err_overflow), 32'd0);
        check("rst_err_timeout", 32'(err_timeout), 32'd0);
        check("rst_cp_activate", 32'(cp_activate), 32'd0);
        check("rst_cp_instr", cp_instr, 32'd0);
        rst_n = 1'b1;
        step(2);

        // Issue latency: push into empty idle FIFO -> activate two cycles later
        resp_delay = 2;
        push(32'h0000_0022, 1'b1);
        check("latency_cycle1", 32'(cp_activate), 32'd0);
        step(1);
        check("latency_cycle2", 32'(cp_activate), 32'd1);
        check("latency_busy", 32'(busy), 32'd1);
        wait_quiet(40, "latency_drain");

        // Table of single transactions
        for (int i = 0; i < 8; i++) begin
            resp_delay = vecs[i].delay;
            resp_data  = vecs[i].data;
            act0   = n_act;
            busy_n = 0;
            push(vecs[i].instr, vecs[i].exp_act == 1);
            repeat (vecs[i].delay + 8) begin
                if (busy) busy_n++;
                @(negedge clk);
            end
            check($sformatf("vec%0d_activates", i), 32'(n_act - act0), 32'(vecs[i].exp_act));
            check($sformatf("vec%0d_busy_cycles", i), 32'(busy_n), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_rdv));
            check($sformatf("vec%0d_fifo_empty", i), 32'(fifo_empty), 32'd1);
            if (vecs[i].exp_rdv) begin
                check($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].exp_rdd));
                rd_ack = 1'b1;
                step(1);
                rd_ack = 1'b0;
                step(1);
                check($sformatf("vec%0d_rd_ack_clears", i), 32'(rd_valid), 32'd0);
            end
        end

        // Illegal opcode followed by WRITE: only the WRITE issues
        resp_delay = 2;
        act0 = n_act;
        push(32'h0000_00AF, 1'b0);
        push(32'h0000_0152, 1'b1);
        wait_quiet(40, "illegal_drain");
        check("illegal_then_write_acts", 32'(n_act - act0), 32'd1);
        check("illegal_then_write_sb", 32'(exp_q.size()), 32'd0);

        // Two READs: second stalls until rd_ack; its capture collides with rd_ack
        resp_delay = 2;
        resp_data  = 16'h00AB;
        act0 = n_act;
        push(32'h0000_0101, 1'b1);
        push(32'h0000_0201, 1'b1);
        step(12);
        check("read1_rd_valid", 32'(rd_valid), 32'd1);
        check("read1_rd_data", 32'(rd_data), 32'h0000_00AB);
        check("read2_stalled_acts", 32'(n_act - act0), 32'd1);
        check("read2_stalled_count", 32'(fifo_count), 32'd1);
        check("read2_stalled_busy", 32'(busy), 32'd0);
        resp_data   = 16'h1111;
        ack_at_done = 1'b1;
        rd_ack = 1'b1;
        step(1);
        rd_ack = 1'b0;
        wait_quiet(40, "read2_drain");
        step(2);
        ack_at_done = 1'b0;
        check("read2_acts", 32'(n_act - act0), 32'd2);
        check("ack_vs_capture_rd_valid", 32'(rd_valid), 32'd1);
        check("read2_rd_data", 32'(rd_data), 32'h0000_1111);
        rd_ack = 1'b1;
        step(1);
        rd_ack = 1'b0;
        check("read2_ack_clears", 32'(rd_valid), 32'd0);

        // Overflow while held in WAIT, then timeout and drain of the queue
        resp_delay = 0;
        act0 = n_act;
        push(32'h0000_0A03, 1'b1);
        k = 0;
        while (cp_activate !== 1'b1 && k < 10) begin
            step(1);
            k++;
        end
        if (k >= 10) begin
            n_total++;
            $display("FAIL ovf_first_issue: got no activate in 10 cycles, expected one");
        end
        t_cyc = cyc;
        for (int i = 0; i < 9; i++) begin
            push(32'hB000_0004 | (32'(i) << 8), i < 8);
        end
        check("ovf_fifo_full", 32'(fifo_full), 32'd1);
        check("ovf_fifo_count", 32'(fifo_count), 32'd8);
        check("ovf_err_overflow", 32'(err_overflow), 32'd1);
        check("ovf_busy_in_wait", 32'(busy), 32'd1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check("ovf_err_clr", 32'(err_overflow), 32'd0);
        err_clr    = 1'b1;
        host_instr = 32'h0000_0EE2;
        host_wr    = 1'b1;
        step(1);
        err_clr = 1'b0;
        host_wr = 1'b0;
        check("ovf_clr_vs_set", 32'(err_overflow), 32'd1);
        check("ovf_count_after_drop", 32'(fifo_count), 32'd8);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check("ovf_err_clr2", 32'(err_overflow), 32'd0);

        while (cyc - t_cyc < TIMEOUT) step(1);
        check("tmo_not_yet", 32'(err_timeout), 32'd0);
        check("tmo_still_busy", 32'(busy), 32'd1);
        resp_delay = 1;
        step(1);
        check("tmo_err_timeout", 32'(err_timeout), 32'd1);
        check("tmo_back_idle", 32'(busy), 32'd0);

        last = -1;
        k = 0;
        while (!(fifo_empty && !busy) && k < 100) begin
            if (cp_activate === 1'b1) begin
                if (last >= 0) check("issue_spacing", 32'(cyc - last), 32'd4);
                last = cyc;
            end
            step(1);
            k++;
        end
        if (k >= 100) begin
            n_total++;
            $display("FAIL tmo_drain: got queue still active after 100 cycles, expected drained");
        end
        step(3);
        check("tmo_drain_acts", 32'(n_act - act0), 32'd9);
        check("tmo_drain_sb", 32'(exp_q.size()), 32'd0);
        check("tmo_err_sticky", 32'(err_timeout), 32'd1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check("tmo_err_clr", 32'(err_timeout), 32'd0);

        // Async reset during WAIT with three words queued
        resp_delay = 0;
        act0 = n_act;
        push(32'h0000_0105, 1'b1);
        push(32'h0000_0206, 1'b0);
        push(32'h0000_0307, 1'b0);
        push(32'h0000_0408, 1'b0);
        check("rstmid_busy_before", 32'(busy), 32'd1);
        check("rstmid_count_before", 32'(fifo_count), 32'd3);
        rst_n = 1'b0;
        #1;
        check("rstmid_fifo_empty", 32'(fifo_empty), 32'd1);
        check("rstmid_count", 32'(fifo_count), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_cp_activate", 32'(cp_activate), 32'd0);
        step(1);
        rst_n = 1'b1;
        step(12);
        check("rstmid_no_issue", 32'(n_act - act0), 32'd1);
        check("rstmid_idle_after", 32'(busy), 32'd0);
        check("rstmid_empty_after", 32'(fifo_empty), 32'd1);
        check("rstmid_sb", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
